// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - HD44780-compatible LCD bus responder with 32-character display buffer
// Synchronises the LCD pins, decodes writes, emulates busy time and mirrors DDRAM on a read port.
module lcd_bus_receiver #(
   parameter int BUSY_CMD = 2000,
   parameter int BUSY_CLR = 76000,
   parameter int BUSY_DAT = 2000,
   parameter int CNT_W    = 17
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic [7:0] LCD_DATA,
   input  logic       LCD_RW,
   input  logic       LCD_EN,
   input  logic       LCD_RS,
   input  logic [4:0] iRD_ADDR,
   output logic [7:0] oRD_DATA,
   output logic       oBUSY,
   output logic       oCMD_VALID,
   output logic [8:0] oCMD,
   output logic       oERR,
   output logic       oDISP_ON,
   output logic       oTWO_LINE
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR, S_WAIT} state_t;

   localparam logic [CNT_W-1:0] LIM_CMD = CNT_W'(BUSY_CMD);
   localparam logic [CNT_W-1:0] LIM_CLR = CNT_W'(BUSY_CLR);
   localparam logic [CNT_W-1:0] LIM_DAT = CNT_W'(BUSY_DAT);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [7:0]       SPACE   = 8'h20;

   logic [10:0]      sync1_q, sync1_d, sync2_q, sync2_d;
   logic             en_prev_q, en_prev_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, lim_q, lim_d;
   logic [4:0]       clr_idx_q, clr_idx_d;
   logic [6:0]       addr_q, addr_d;
   logic             id_q, id_d;
   logic             busy_q, busy_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [8:0]       cmd_q, cmd_d;
   logic             err_q, err_d;
   logic             disp_on_q, disp_on_d;
   logic             two_line_q, two_line_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic [7:0]       buf_q [32];
   logic [7:0]       buf_d [32];

   logic       strobe, rs_in, rw_in, write_req;
   logic [7:0] dat_in;

   // Two-line DDRAM stepping: line 1 ends at 0x27, line 2 at 0x67, and they wrap into each other.
   function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
      if (inc) begin
         if (a == 7'h27) return 7'h40;
         if (a == 7'h67) return 7'h00;
         return a + 7'd1;
      end
      if (a == 7'h00) return 7'h67;
      if (a == 7'h40) return 7'h27;
      return a - 7'd1;
   endfunction

   function automatic logic is_mapped(input logic [6:0] a);
      return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
   endfunction

   always_comb begin
      sync1_d   = {LCD_EN, LCD_RS, LCD_RW, LCD_DATA};
      sync2_d   = sync1_q;
      en_prev_d = sync2_q[10];
      strobe    = en_prev_q & ~sync2_q[10];
      rs_in     = sync2_q[9];
      rw_in     = sync2_q[8];
      dat_in    = sync2_q[7:0];
      write_req = strobe & ~rw_in;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lim_d       = lim_q;
      clr_idx_d   = clr_idx_q;
      addr_d      = addr_q;
      id_d        = id_q;
      cmd_valid_d = 1'b0;
      cmd_d       = cmd_q;
      err_d       = write_req & busy_q;
      disp_on_d   = disp_on_q;
      two_line_d  = two_line_q;
      buf_d       = buf_q;
      rd_data_d   = buf_q[iRD_ADDR];

      case (state_q)
         S_IDLE: begin
            if (write_req) begin
               cmd_valid_d = 1'b1;
               cmd_d       = {rs_in, dat_in};
               cnt_d       = '0;
               state_d     = S_EXEC;
               if (rs_in) begin
                  lim_d = LIM_DAT;
                  if (is_mapped(addr_q)) buf_d[{addr_q[6], addr_q[3:0]}] = dat_in;
                  addr_d = step_addr(addr_q, id_q);
               end else begin
                  lim_d = (dat_in == 8'h01) ? LIM_CLR : LIM_CMD;
                  casez (dat_in)
                     8'b1???????: addr_d = dat_in[6:0];
                     8'b01??????: ;
                     8'b001?????: two_line_d = dat_in[3];
                     8'b0001????: if (!dat_in[3]) addr_d = step_addr(addr_q, dat_in[2]);
                     8'b00001???: disp_on_d = dat_in[2];
                     8'b000001??: id_d = dat_in[1];
                     8'b0000001?: addr_d = 7'h00;
                     8'b00000001: begin
                        addr_d = 7'h00;
                        id_d   = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_EXEC: begin
            cnt_d     = cnt_q + ONE;
            clr_idx_d = '0;
            state_d   = (cmd_q == 9'h001) ? S_CLEAR : S_WAIT;
         end
         S_CLEAR: begin
            buf_d[clr_idx_q] = SPACE;
            cnt_d            = cnt_q + ONE;
            clr_idx_d        = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) state_d = S_WAIT;
         end
         default: begin
            // Busy time counts from the EXEC cycle, so the last WAIT cycle is lim-1.
            if (cnt_q >= lim_q - ONE) state_d = S_IDLE;
            else cnt_d = cnt_q + ONE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         en_prev_q   <= 1'b0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lim_q       <= '0;
         clr_idx_q   <= '0;
         addr_q      <= 7'h00;
         id_q        <= 1'b1;
         busy_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_q       <= '0;
         err_q       <= 1'b0;
         disp_on_q   <= 1'b0;
         two_line_q  <= 1'b0;
         rd_data_q   <= SPACE;
         for (int i = 0; i < 32; i++) buf_q[i] <= SPACE;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         en_prev_q   <= en_prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lim_q       <= lim_d;
         clr_idx_q   <= clr_idx_d;
         addr_q      <= addr_d;
         id_q        <= id_d;
         busy_q      <= busy_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_q       <= cmd_d;
         err_q       <= err_d;
         disp_on_q   <= disp_on_d;
         two_line_q  <= two_line_d;
         rd_data_q   <= rd_data_d;
         buf_q       <= buf_d;
      end
   end

   assign oRD_DATA   = rd_data_q;
   assign oBUSY      = busy_q;
   assign oCMD_VALID = cmd_valid_q;
   assign oCMD       = cmd_q;
   assign oERR       = err_q;
   assign oDISP_ON   = disp_on_q;
   assign oTWO_LINE  = two_line_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - self-checking bench for lcd_bus_receiver
// Table-driven init sequence, directed corner cases and random writes against a DDRAM model.
module tb_lcd_bus_receiver;
   localparam int BC   = 60;
   localparam int BCLR = 120;
   localparam int BD   = 150;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] lcd_data;
   logic       lcd_rw, lcd_en, lcd_rs;
   logic [4:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy, cmd_valid, err, disp_on, two_line;
   logic [8:0] cmd;

   lcd_bus_receiver #(.BUSY_CMD(BC), .BUSY_CLR(BCLR), .BUSY_DAT(BD), .CNT_W(17)) dut (
      .iCLK(clk), .iRST(rst), .LCD_DATA(lcd_data), .LCD_RW(lcd_rw), .LCD_EN(lcd_en),
      .LCD_RS(lcd_rs), .iRD_ADDR(rd_addr), .oRD_DATA(rd_data), .oBUSY(busy),
      .oCMD_VALID(cmd_valid), .oCMD(cmd), .oERR(err), .oDISP_ON(disp_on), .oTWO_LINE(two_line)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   int         cmd_cnt = 0, err_cnt = 0, busy_run = 0, last_busy = 0;
   logic [8:0] last_cmd = '0;

   always @(posedge clk) begin
      #2;
      if (cmd_valid) begin
         cmd_cnt++;
         last_cmd = cmd;
      end
      if (err) err_cnt++;
      if (rst) busy_run = 0;
      else if (busy) busy_run++;
      else if (busy_run != 0) begin
         last_busy = busy_run;
         busy_run  = 0;
      end
   end

   // Behavioural model: DDRAM as 80 positions of a ring in two-line mode.
   logic [7:0] m_buf [32];
   int         m_addr;
   bit         m_id, m_disp, m_two;

   function automatic int m_step(input int a, input bit inc);
      int pos;
      if (a <= 'h27 || (a >= 'h40 && a <= 'h67)) begin
         pos = (a < 'h40) ? a : a - 'h40 + 40;
         pos = (pos + (inc ? 1 : 79)) % 80;
         return (pos < 40) ? pos : pos - 40 + 'h40;
      end
      return (a + (inc ? 1 : 127)) % 128;
   endfunction

   function automatic int m_idx(input int a);
      if (a < 16) return a;
      if (a >= 'h40 && a < 'h50) return a - 'h40 + 16;
      return -1;
   endfunction

   function automatic int busy_of(input bit rs, input logic [7:0] d);
      if (rs) return BD;
      return (d == 8'h01) ? BCLR : BC;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
      m_addr = 0; m_id = 1; m_disp = 0; m_two = 0;
   endtask

   task automatic m_write(input bit rs, input logic [7:0] d);
      int ix;
      if (rs) begin
         ix = m_idx(m_addr);
         if (ix >= 0) m_buf[ix] = d;
         m_addr = m_step(m_addr, m_id);
      end else if (d[7]) m_addr = d[6:0];
      else if (d[6]) ;
      else if (d[5]) m_two = d[3];
      else if (d[4]) begin
         if (!d[3]) m_addr = m_step(m_addr, d[2]);
      end
      else if (d[3]) m_disp = d[2];
      else if (d[2]) m_id = d[1];
      else if (d[1]) m_addr = 0;
      else if (d[0]) begin
         for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
         m_addr = 0; m_id = 1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic lcd_strobe(input bit rs, input bit rw, input logic [7:0] d);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
      repeat (4) @(negedge clk);
      lcd_en = 1'b0;
      repeat (6) @(negedge clk);
      lcd_rw = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("busy_timeout", 1, 0);
      @(negedge clk);
   endtask

   task automatic read_buf(input int i, output logic [7:0] v);
      @(negedge clk);
      rd_addr = 5'(i);
      @(negedge clk);
      v = rd_data;
   endtask

   task automatic compare_buf(input string name);
      logic [7:0] v;
      for (int i = 0; i < 32; i++) begin
         read_buf(i, v);
         chk($sformatf("%s_buf%0d", name, i), v, m_buf[i]);
      end
   endtask

   // Full accepted write: checks pulse, oCMD, busy length and flags; optional second strobe while busy.
   task automatic do_write(input bit rs, input logic [7:0] d, input bit hit_busy);
      int c0, e0;
      c0 = cmd_cnt; e0 = err_cnt;
      lcd_strobe(rs, 1'b0, d);
      chk("accept_pulse", cmd_cnt, c0 + 1);
      chk("cmd_word", last_cmd, {rs, d});
      chk("busy_set", busy, 1);
      m_write(rs, d);
      if (hit_busy) begin
         lcd_strobe(~rs, 1'b0, ~d);
         chk("busy_err_pulse", err_cnt, e0 + 1);
         chk("busy_no_accept", cmd_cnt, c0 + 1);
      end
      wait_idle();
      chk("busy_len", last_busy, busy_of(rs, d));
      chk("err_none", err_cnt, e0 + (hit_busy ? 1 : 0));
      chk("disp_on", disp_on, m_disp);
      chk("two_line", two_line, m_two);
   endtask

   typedef struct {
      bit         rs;
      logic [7:0] d;
      bit         exp_two;
      bit         exp_disp;
   } vec_t;

   initial begin
      vec_t       tbl[$];
      logic [7:0] v;
      int         c0, e0;
      bit         rs;
      logic [7:0] d;

      rst = 1'b1; lcd_data = '0; lcd_rw = 0; lcd_en = 0; lcd_rs = 0; rd_addr = '0;
      m_reset();
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd", cmd, 0);
      chk("rst_err", err, 0);
      chk("rst_disp", disp_on, 0);
      chk("rst_two", two_line, 0);
      chk("rst_rd_data", rd_data, 8'h20);
      rst = 1'b0;

      // Init sequence with extra toggles of N and display-on.
      tbl.push_back('{0, 8'h38, 1, 0});
      tbl.push_back('{0, 8'h0C, 1, 1});
      tbl.push_back('{0, 8'h01, 1, 1});
      tbl.push_back('{0, 8'h06, 1, 1});
      tbl.push_back('{0, 8'h30, 0, 1});
      tbl.push_back('{0, 8'h08, 0, 0});
      tbl.push_back('{0, 8'h38, 1, 0});
      tbl.push_back('{0, 8'h0C, 1, 1});
      tbl.push_back('{0, 8'h80, 1, 1});
      tbl.push_back('{1, 8'h57, 1, 1});
      c0 = cmd_cnt;
      foreach (tbl[i]) begin
         do_write(tbl[i].rs, tbl[i].d, 1'b0);
         chk($sformatf("tbl%0d_two", i), two_line, tbl[i].exp_two);
         chk($sformatf("tbl%0d_disp", i), disp_on, tbl[i].exp_disp);
      end
      chk("init_pulses", cmd_cnt - c0, tbl.size());
      chk("init_err", err_cnt, 0);
      read_buf(0, v);
      chk("init_buf0", v, 8'h57);
      compare_buf("init");

      // Unmapped 0x27 then wrap into line 2.
      do_write(0, 8'hA7, 0);
      do_write(1, 8'h41, 0);
      do_write(1, 8'h42, 0);
      read_buf(16, v);
      chk("wrap_buf16", v, 8'h42);
      compare_buf("wrap");

      // Decrement from 0x00 to 0x67 (unmapped).
      do_write(0, 8'h04, 0);
      do_write(0, 8'h80, 0);
      do_write(1, 8'h58, 0);
      do_write(1, 8'h59, 0);
      read_buf(0, v);
      chk("dec_buf0", v, 8'h58);
      compare_buf("dec");
      do_write(0, 8'h06, 0);

      // Strobe while busy is dropped with an error pulse.
      do_write(0, 8'h80, 0);
      c0 = cmd_cnt; e0 = err_cnt;
      lcd_strobe(1, 0, 8'h41);
      m_write(1, 8'h41);
      repeat (88) @(negedge clk);
      lcd_strobe(1, 0, 8'h42);
      chk("err_once", err_cnt, e0 + 1);
      chk("err_dropped", cmd_cnt, c0 + 1);
      wait_idle();
      chk("err_busy_len", last_busy, BD);
      compare_buf("err");

      // Read strobes are ignored.
      c0 = cmd_cnt; e0 = err_cnt;
      lcd_strobe(1, 1, 8'h55);
      lcd_strobe(0, 1, 8'h01);
      chk("read_no_pulse", cmd_cnt, c0);
      chk("read_no_err", err_cnt, e0);

      // Fill line 1, then clear.
      do_write(0, 8'h80, 0);
      for (int i = 0; i < 16; i++) do_write(1, 8'h41, 0);
      read_buf(15, v);
      chk("fill_buf15", v, 8'h41);
      do_write(0, 8'h01, 0);
      chk("clear_busy_len", last_busy, BCLR);
      for (int i = 0; i < 32; i++) begin
         read_buf(i, v);
         chk($sformatf("clear_buf%0d", i), v, 8'h20);
      end

      // Reset in the middle of CLEAR.
      do_write(0, 8'h80, 0);
      do_write(1, 8'h5A, 0);
      lcd_strobe(0, 0, 8'h01);
      repeat (8) @(negedge clk);
      chk("midclr_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rd", rd_data, 8'h20);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      compare_buf("rst_mid");
      chk("rst_mid_disp", disp_on, 0);
      do_write(0, 8'h80, 0);

      // Random writes, some hitting busy, checked against the model.
      for (int n = 0; n < 60; n++) begin
         rs = 1'($urandom);
         d  = 8'($urandom);
         if (!rs && $urandom_range(0, 1) == 1) d = {1'b1, 1'($urandom), 2'b00, 4'($urandom)};
         do_write(rs, d, $urandom_range(0, 7) == 0);
         if (n % 10 == 9) compare_buf($sformatf("rnd%0d", n));
      end
      compare_buf("rnd_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
